prog_launcher: RTL and testbench
================================

Name: prog_launcher

Overview:
- Sits directly upstream of the CPU top level. Accepts a stream of 9-bit machine-code words and writes them into the instruction memory write port.
- Holds the CPU in reset while the program loads, then releases reset and pulses req.
- Counts execution cycles until the CPU raises done or a cycle budget expires, and reports the result.

Parameters:
- D, 10, instruction address / program counter width
- W, 9, machine-code word width
- CW, 16, cycle counter and budget width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_word is valid
- in_ready  out  1  block accepts a word this cycle
- in_word  in  W  machine-code word
- in_last  in  1  marks the final word of the program
- rearm  in  1  pulse in FIN/TMO: return to LOAD for a new program
- max_cycles  in  CW  cycle budget; 0 means no timeout
- imem_wr_en  out  1  instruction memory write strobe
- imem_addr  out  D  instruction memory write address
- imem_dat  out  W  instruction memory write data
- cpu_reset  out  1  reset to the CPU
- cpu_req  out  1  start request to the CPU
- cpu_done  in  1  CPU done flag
- prog_len  out  D+1  number of words loaded
- cycle_cnt  out  CW  RUN cycles counted
- finished  out  1  CPU completed (sticky until rearm/reset)
- timeout  out  1  budget expired (sticky until rearm/reset)

Behaviour:
- States: LOAD, ARM, RUN, FIN, TMO.
- Reset (async): state=LOAD, prog_len=0, cycle_cnt=0.
  - Outputs: imem_wr_en=0, imem_addr=0, imem_dat=0, cpu_reset=1, cpu_req=0, finished=0, timeout=0.
- All outputs are registered, except in_ready = (state==LOAD).
- LOAD:
  - Accept a word when in_valid & in_ready.
  - The cycle after acceptance: imem_wr_en=1, imem_addr=prog_len (pre-increment), imem_dat=word, and prog_len increments. 1-cycle write latency.
  - Go to ARM on acceptance of a word with in_last=1.
  - Go to ARM on acceptance of word number 2^D, i.e. prog_len reaches 2^D. in_last is ignored in that case.
  - in_valid without acceptance has no effect.
- ARM:
  - Lasts exactly 1 cycle; the final write lands during it.
  - in_ready=0, cpu_reset=1, cycle_cnt cleared to 0. Next state is RUN.
- RUN:
  - cpu_reset=0. cpu_req=1 in the first RUN cycle only.
  - cycle_cnt increments every RUN cycle, including the cycle in which cpu_done is sampled. Done seen in the 1st RUN cycle gives cycle_cnt=1.
  - cpu_done=1 → FIN.
  - Otherwise, if max_cycles!=0 and cycle_cnt+1==max_cycles → TMO, so cycle_cnt=max_cycles at TMO.
  - cpu_done and budget expiry in the same cycle: FIN wins, timeout=0.
  - With max_cycles=0, cycle_cnt saturates at 2^CW-1 and never wraps.
- FIN: finished=1, cpu_reset=1, cycle_cnt and prog_len frozen.
- TMO: timeout=1, cpu_reset=1, cycle_cnt and prog_len frozen.
- rearm in FIN/TMO: next state LOAD.
  - Clears prog_len, cycle_cnt, finished and timeout. Keeps cpu_reset=1.
  - rearm is ignored in all other states.
- cpu_done is ignored in LOAD and ARM, because the CPU is held in reset.
- imem_wr_en is never asserted outside the cycle following an acceptance.
- Reset asserted mid-LOAD or mid-RUN: immediate return to reset values. A partial program is abandoned; memory contents are not cleared.

Test Plan:
- Load 5 words 0x101..0x105, last on the 5th, max_cycles=100, cpu_done high 20 cycles after req.
  → writes at addr 0..4 with matching data, prog_len=5, one-cycle cpu_req, finished=1, cycle_cnt=21, cpu_reset back to 1.
- max_cycles=10, cpu_done never asserted → timeout=1 after 10 RUN cycles, cycle_cnt=10, finished=0.
- cpu_done rises in exactly the 10th RUN cycle with max_cycles=10 → finished=1, timeout=0, cycle_cnt=10.
- Stream 1024 words with in_last never set → state ARM after word 1024, prog_len=1024, last write at addr 1023, in_ready=0.
- Assert reset during RUN after 7 cycles → all outputs return to reset values asynchronously, state LOAD, in_ready=1.
- From FIN, pulse rearm; then load 1 word with in_last=1 and cpu_done held high → prog_len=1, finished=1, cycle_cnt=1.

Source files
------------

// File: rtl/prog_launcher.sv
// Program loader and run supervisor: streams machine code into instruction memory,
// holds the CPU in reset while loading, then runs it against an optional cycle budget.
module prog_launcher #(
  parameter int unsigned D  = 10,
  parameter int unsigned W  = 9,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_word,
  input  logic          in_last,
  input  logic          rearm,
  input  logic [CW-1:0] max_cycles,
  output logic          imem_wr_en,
  output logic [D-1:0]  imem_addr,
  output logic [W-1:0]  imem_dat,
  output logic          cpu_reset,
  output logic          cpu_req,
  input  logic          cpu_done,
  output logic [D:0]    prog_len,
  output logic [CW-1:0] cycle_cnt,
  output logic          finished,
  output logic          timeout
);

  typedef enum logic [2:0] {S_LOAD, S_ARM, S_RUN, S_FIN, S_TMO} state_t;

  localparam logic [D:0]  LEN_ONE = 1;
  localparam logic [CW:0] CNT_ONE = 1;

  state_t        r_state, w_next;
  logic          r_wr_en, r_cpu_reset, r_cpu_req, r_finished, r_timeout;
  logic [D-1:0]  r_addr;
  logic [W-1:0]  r_dat;
  logic [D:0]    r_prog_len;
  logic [CW-1:0] r_cycle_cnt;

  logic          w_accept;
  logic [D:0]    w_len_inc;
  logic [CW:0]   w_cnt_plus1;
  logic [CW-1:0] w_cnt_sat;
  logic          w_budget_hit;

  assign w_accept     = in_valid && (r_state == S_LOAD);
  assign w_len_inc    = r_prog_len + LEN_ONE;
  assign w_cnt_plus1  = {1'b0, r_cycle_cnt} + CNT_ONE;
  // Carry out of the increment means the counter is already all-ones: hold it.
  assign w_cnt_sat    = w_cnt_plus1[CW] ? r_cycle_cnt : w_cnt_plus1[CW-1:0];
  assign w_budget_hit = (max_cycles != '0) && (w_cnt_plus1 == {1'b0, max_cycles});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      // Bit D of the incremented length set means memory is full (2^D words).
      S_LOAD:  if (w_accept && (in_last || w_len_inc[D])) w_next = S_ARM;
      S_ARM:   w_next = S_RUN;
      S_RUN: begin
        if (cpu_done)          w_next = S_FIN;
        else if (w_budget_hit) w_next = S_TMO;
      end
      S_FIN, S_TMO: if (rearm) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_dat       <= '0;
      r_prog_len  <= '0;
      r_cycle_cnt <= '0;
      r_cpu_reset <= 1'b1;
      r_cpu_req   <= 1'b0;
      r_finished  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_addr     <= r_prog_len[D-1:0];
        r_dat      <= in_word;
        r_prog_len <= w_len_inc;
      end
      case (r_state)
        S_ARM: r_cycle_cnt <= '0;
        S_RUN: r_cycle_cnt <= w_cnt_sat;
        S_FIN, S_TMO: begin
          if (rearm) begin
            r_prog_len  <= '0;
            r_cycle_cnt <= '0;
          end
        end
        default: ;
      endcase
      r_cpu_reset <= (w_next != S_RUN);
      r_cpu_req   <= (r_state == S_ARM);
      r_finished  <= (w_next == S_FIN);
      r_timeout   <= (w_next == S_TMO);
    end
  end

  assign in_ready   = (r_state == S_LOAD);
  assign imem_wr_en = r_wr_en;
  assign imem_addr  = r_addr;
  assign imem_dat   = r_dat;
  assign cpu_reset  = r_cpu_reset;
  assign cpu_req    = r_cpu_req;
  assign prog_len   = r_prog_len;
  assign cycle_cnt  = r_cycle_cnt;
  assign finished   = r_finished;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher: random programs and run scenarios checked
// against expected write streams and run outcomes derived from the launcher's rules.
module tb_prog_launcher;

  localparam int D  = 10;
  localparam int W  = 9;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_word;
  logic          in_last;
  logic          rearm;
  logic [CW-1:0] max_cycles;
  logic          imem_wr_en;
  logic [D-1:0]  imem_addr;
  logic [W-1:0]  imem_dat;
  logic          cpu_reset;
  logic          cpu_req;
  logic          cpu_done;
  logic [D:0]    prog_len;
  logic [CW-1:0] cycle_cnt;
  logic          finished;
  logic          timeout;

  int n_cmp = 0;
  int n_err = 0;
  int cur_len = 0;

  always #5 clk = ~clk;

  prog_launcher #(.D(D), .W(W), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_last    (in_last),
    .rearm      (rearm),
    .max_cycles (max_cycles),
    .imem_wr_en (imem_wr_en),
    .imem_addr  (imem_addr),
    .imem_dat   (imem_dat),
    .cpu_reset  (cpu_reset),
    .cpu_req    (cpu_req),
    .cpu_done   (cpu_done),
    .prog_len   (prog_len),
    .cycle_cnt  (cycle_cnt),
    .finished   (finished),
    .timeout    (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 1);
    check({tag, "_wr_en"}, 32'(imem_wr_en), 0);
    check({tag, "_addr"},  32'(imem_addr), 0);
    check({tag, "_dat"},   32'(imem_dat), 0);
    check({tag, "_cpurst"}, 32'(cpu_reset), 1);
    check({tag, "_req"},   32'(cpu_req), 0);
    check({tag, "_len"},   32'(prog_len), 0);
    check({tag, "_cnt"},   32'(cycle_cnt), 0);
    check({tag, "_fin"},   32'(finished), 0);
    check({tag, "_tmo"},   32'(timeout), 0);
  endtask

  // Words go to consecutive addresses from 0; base < 0 selects random data.
  task automatic load_prog(input int n, input int base, input bit use_last);
    logic [W-1:0] w;
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        in_valid = 1'b0;
        in_word  = W'($urandom);
        cpu_done = 1'($urandom_range(0, 1));
        tick();
        check("idle_wr", 32'(imem_wr_en), 0);
      end
      w = (base >= 0) ? W'(base + i + 1) : W'($urandom);
      in_valid = 1'b1;
      in_word  = w;
      in_last  = use_last && (i == n - 1);
      cpu_done = 1'($urandom_range(0, 1));
      check("ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("wr_en", 32'(imem_wr_en), 1);
      check("wr_addr", 32'(imem_addr), i);
      check("wr_dat", 32'(imem_dat), 32'(w));
      check("len", 32'(prog_len), i + 1);
    end
    cpu_done = 1'b0;
    cur_len  = n;
    check("arm_ready", 32'(in_ready), 0);
    check("arm_cpurst", 32'(cpu_reset), 1);
  endtask

  // Entered during the ARM cycle. done_at: first RUN cycle with cpu_done high (0 = never).
  // stop_after: return at the start of that RUN cycle without finishing.
  task automatic run_prog(input int m, input int done_at, input int stop_after);
    bit fin;
    int end_k;
    int last_k;
    int hold;
    fin    = (done_at != 0) && (m == 0 || done_at <= m);
    end_k  = fin ? done_at : m;
    last_k = 0;
    max_cycles = CW'(m);
    tick();
    for (int k = 1; k <= 4000; k++) begin
      check("run_cnt", 32'(cycle_cnt), k - 1);
      check("run_req", 32'(cpu_req), (k == 1) ? 1 : 0);
      check("run_cpurst", 32'(cpu_reset), 0);
      check("run_wr", 32'(imem_wr_en), 0);
      if (k == stop_after) return;
      cpu_done = (done_at != 0) && (k >= done_at);
      in_valid = 1'($urandom_range(0, 1));
      rearm    = 1'($urandom_range(0, 1));
      tick();
      in_valid = 1'b0;
      rearm    = 1'b0;
      last_k   = k;
      if (k == end_k) break;
    end
    check("run_len", last_k, end_k);
    check("end_fin", 32'(finished), fin ? 1 : 0);
    check("end_tmo", 32'(timeout), fin ? 0 : 1);
    check("end_cnt", 32'(cycle_cnt), end_k);
    check("end_cpurst", 32'(cpu_reset), 1);
    check("end_req", 32'(cpu_req), 0);
    check("end_wr", 32'(imem_wr_en), 0);
    hold = int'($urandom_range(1, 4));
    repeat (hold) begin
      cpu_done = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check("hold_ready", 32'(in_ready), 0);
      check("hold_fin", 32'(finished), fin ? 1 : 0);
      check("hold_tmo", 32'(timeout), fin ? 0 : 1);
      check("hold_cnt", 32'(cycle_cnt), end_k);
      check("hold_len", 32'(prog_len), cur_len);
      check("hold_wr", 32'(imem_wr_en), 0);
    end
    in_valid = 1'b0;
    cpu_done = 1'b0;
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    check("rearm_ready", 32'(in_ready), 1);
    check("rearm_len", 32'(prog_len), 0);
    check("rearm_cnt", 32'(cycle_cnt), 0);
    check("rearm_fin", 32'(finished), 0);
    check("rearm_tmo", 32'(timeout), 0);
    check("rearm_cpurst", 32'(cpu_reset), 1);
  endtask

  initial begin
    int n, m, d;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_word    = '0;
    in_last    = 1'b0;
    rearm      = 1'b0;
    max_cycles = '0;
    cpu_done   = 1'b0;
    #3;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    load_prog(5, 'h100, 1'b1);
    run_prog(100, 21, 0);
    do_rearm();

    load_prog(int'($urandom_range(1, 8)), -1, 1'b1);
    run_prog(10, 0, 0);
    do_rearm();

    load_prog(int'($urandom_range(1, 8)), -1, 1'b1);
    run_prog(10, 10, 0);
    do_rearm();

    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(1, 20));
      m = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      d = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      if (m == 0 && d == 0) d = int'($urandom_range(1, 40));
      load_prog(n, -1, 1'b1);
      run_prog(m, d, 0);
      do_rearm();
    end

    load_prog(1 << D, -1, 1'b0);
    run_prog(0, 3, 0);
    do_rearm();

    load_prog(3, -1, 1'b1);
    run_prog(0, 0, 8);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrun");
    #1;
    reset = 1'b0;

    load_prog(2, -1, 1'b1);
    run_prog(0, 4, 0);
    do_rearm();
    load_prog(1, -1, 1'b1);
    run_prog(0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
